// File: rtl/shared_buffer_pool_manager.sv
// Free-slot manager for one input port's shared flit buffer: a FIFO free list plus
// per-VC occupancy, with min_reserved slots held back for every VC below its minimum.
module shared_buffer_pool_manager #(
    parameter int num_slots    = 32,
    parameter int num_vcs      = 4,
    parameter int min_reserved = 1,
    localparam int slot_addr_width = (num_slots > 1) ? $clog2(num_slots) : 1,
    localparam int vc_idx_width    = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int count_width     = $clog2(num_slots + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_req_i,
    input  logic [vc_idx_width-1:0]    alloc_vc_i,
    output logic                       alloc_gnt_o,
    output logic [slot_addr_width-1:0] alloc_slot_o,
    input  logic                       free_valid_i,
    input  logic [vc_idx_width-1:0]    free_vc_i,
    input  logic [slot_addr_width-1:0] free_slot_i,
    output logic [count_width-1:0]     free_count_o,
    output logic [num_vcs-1:0]         vc_can_alloc_o,
    output logic                       pool_empty_o,
    output logic                       free_error_o
);
    localparam logic [count_width-1:0]     NumSlotsC = count_width'(num_slots);
    localparam logic [count_width-1:0]     MinResC   = count_width'(min_reserved);
    localparam logic [count_width-1:0]     ResvInitC = count_width'(num_vcs * min_reserved);
    localparam logic [slot_addr_width-1:0] LastSlotC = slot_addr_width'(num_slots - 1);

    logic [slot_addr_width-1:0] slot_q [num_slots];
    logic [slot_addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [slot_addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [count_width-1:0]     free_count_q, free_count_d;
    logic [count_width-1:0]     used_q [num_vcs];
    logic [count_width-1:0]     used_d [num_vcs];
    logic [count_width-1:0]     resv_q, resv_d;
    logic                       free_error_q, free_error_d;
    logic [num_vcs-1:0]         can_alloc;
    logic                       gnt;
    logic                       free_legal;
    logic [count_width-1:0]     free_vc_used;

    function automatic logic [slot_addr_width-1:0] next_ptr(input logic [slot_addr_width-1:0] p);
        return (p == LastSlotC) ? '0 : p + slot_addr_width'(1);
    endfunction

    // A VC still under its minimum draws from its own reservation; otherwise it may
    // only take slots beyond what other VCs are still owed.
    always_comb begin
        can_alloc = '0;
        for (int v = 0; v < num_vcs; v++) begin
            can_alloc[v] = (used_q[v] < MinResC) ? (free_count_q != '0)
                                                 : (free_count_q > resv_q);
        end
    end

    always_comb begin
        gnt          = 1'b0;
        free_vc_used = '0;
        for (int v = 0; v < num_vcs; v++) begin
            if (alloc_vc_i == vc_idx_width'(v)) begin
                gnt = alloc_req_i & can_alloc[v];
            end
            if (free_vc_i == vc_idx_width'(v)) begin
                free_vc_used = used_q[v];
            end
        end
    end

    assign free_legal   = free_valid_i && (free_vc_used != '0) && (free_count_q != NumSlotsC);
    assign free_error_d = free_valid_i && !free_legal;

    // Reservation debt is recomputed from next-state occupancy so simultaneous
    // grant/free on the same or different VCs nets out without special cases.
    always_comb begin
        resv_d = '0;
        for (int v = 0; v < num_vcs; v++) begin
            used_d[v] = used_q[v];
            if (gnt && (alloc_vc_i == vc_idx_width'(v)) &&
                !(free_legal && (free_vc_i == vc_idx_width'(v)))) begin
                used_d[v] = used_q[v] + count_width'(1);
            end else if (free_legal && (free_vc_i == vc_idx_width'(v)) &&
                         !(gnt && (alloc_vc_i == vc_idx_width'(v)))) begin
                used_d[v] = used_q[v] - count_width'(1);
            end
            resv_d = resv_d + ((used_d[v] < MinResC) ? (MinResC - used_d[v]) : '0);
        end
    end

    always_comb begin
        rd_ptr_d = gnt ? next_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = free_legal ? next_ptr(wr_ptr_q) : wr_ptr_q;
        case ({free_legal, gnt})
            2'b10:   free_count_d = free_count_q + count_width'(1);
            2'b01:   free_count_d = free_count_q - count_width'(1);
            default: free_count_d = free_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_count_q <= NumSlotsC;
            resv_q       <= ResvInitC;
            free_error_q <= 1'b0;
            for (int v = 0; v < num_vcs; v++) begin
                used_q[v] <= '0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            free_count_q <= free_count_d;
            resv_q       <= resv_d;
            free_error_q <= free_error_d;
            for (int v = 0; v < num_vcs; v++) begin
                used_q[v] <= used_d[v];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_slots; i++) begin
                slot_q[i] <= slot_addr_width'(i);
            end
        end else if (free_legal) begin
            slot_q[wr_ptr_q] <= free_slot_i;
        end
    end

    assign alloc_gnt_o    = gnt;
    assign alloc_slot_o   = slot_q[rd_ptr_q];
    assign free_count_o   = free_count_q;
    assign vc_can_alloc_o = can_alloc;
    assign pool_empty_o   = (free_count_q == '0);
    assign free_error_o   = free_error_q;

endmodule

// File: tb/tb_shared_buffer_pool_manager.sv
// Directed bench for shared_buffer_pool_manager (8 slots, 2 VCs, 2 reserved each)
// with a free-list queue model and a grant/slot scoreboard.
module tb_shared_buffer_pool_manager;
    localparam int NS = 8;
    localparam int NV = 2;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_i;
    logic [0:0] alloc_vc_i;
    logic       alloc_gnt_o;
    logic [2:0] alloc_slot_o;
    logic       free_valid_i;
    logic [0:0] free_vc_i;
    logic [2:0] free_slot_i;
    logic [3:0] free_count_o;
    logic [1:0] vc_can_alloc_o;
    logic       pool_empty_o;
    logic       free_error_o;

    shared_buffer_pool_manager #(
        .num_slots   (NS),
        .num_vcs     (NV),
        .min_reserved(MR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req_i   (alloc_req_i),
        .alloc_vc_i    (alloc_vc_i),
        .alloc_gnt_o   (alloc_gnt_o),
        .alloc_slot_o  (alloc_slot_o),
        .free_valid_i  (free_valid_i),
        .free_vc_i     (free_vc_i),
        .free_slot_i   (free_slot_i),
        .free_count_o  (free_count_o),
        .vc_can_alloc_o(vc_can_alloc_o),
        .pool_empty_o  (pool_empty_o),
        .free_error_o  (free_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        int slot;
    } exp_t;

    int   n_total = 0;
    int   n_pass  = 0;
    int   fq[$];
    int   used_m[NV];
    bit   err_m;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int resv_m();
        int s = 0;
        for (int v = 0; v < NV; v++) s += (used_m[v] < MR) ? (MR - used_m[v]) : 0;
        return s;
    endfunction

    function automatic bit can_m(input int v);
        if (used_m[v] < MR) return fq.size() > 0;
        return fq.size() > resv_m();
    endfunction

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < NS; i++) fq.push_back(i);
        for (int v = 0; v < NV; v++) used_m[v] = 0;
        err_m = 1'b0;
        sb.delete();
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input bit req, input int vc, input bit fv, input int fvc, input int fs);
        bit   g;
        bit   legal;
        exp_t e;
        alloc_req_i  = req;
        alloc_vc_i   = 1'(vc);
        free_valid_i = fv;
        free_vc_i    = 1'(fvc);
        free_slot_i  = 3'(fs);
        g = req && can_m(vc);
        e.gnt  = g;
        e.slot = g ? fq[0] : 0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("gnt", 32'(alloc_gnt_o), 32'(e.gnt));
        if (e.gnt) chk("slot", 32'(alloc_slot_o), 32'(e.slot));
        legal = fv && (used_m[fvc] > 0) && (fq.size() < NS);
        if (g) begin
            void'(fq.pop_front());
            used_m[vc]++;
        end
        if (legal) begin
            fq.push_back(fs);
            used_m[fvc]--;
        end
        err_m = fv && !legal;
        @(negedge clk);
        alloc_req_i  = 1'b0;
        free_valid_i = 1'b0;
        chk("free_count", 32'(free_count_o), 32'(fq.size()));
        chk("free_error", 32'(free_error_o), 32'(err_m));
        chk("vc_can_alloc", 32'(vc_can_alloc_o), 32'({can_m(1), can_m(0)}));
    endtask

    initial begin
        reset        = 1'b0;
        alloc_req_i  = 1'b0;
        alloc_vc_i   = '0;
        free_valid_i = 1'b0;
        free_vc_i    = '0;
        free_slot_i  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_free_count", 32'(free_count_o), 32'd8);
        chk("rst_alloc_slot", 32'(alloc_slot_o), 32'd0);
        chk("rst_vc_can", 32'(vc_can_alloc_o), 32'b11);
        chk("rst_pool_empty", 32'(pool_empty_o), 32'd0);
        chk("rst_free_error", 32'(free_error_o), 32'd0);

        // VC0 takes its reservation then shares until VC1's reservation is reached
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
        chk("vc0_blocked_can", 32'(vc_can_alloc_o), 32'b10);
        chk("vc0_blocked_count", 32'(free_count_o), 32'd2);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("full_pool_empty", 32'(pool_empty_o), 32'd1);
        chk("full_vc_can", 32'(vc_can_alloc_o), 32'b00);
        cyc(1, 0, 0, 0, 0);

        // Free slot 3 at the wrapped tail, then reallocate it from the wrapped head
        cyc(0, 0, 1, 0, 3);
        chk("refree_count", 32'(free_count_o), 32'd1);
        chk("wrap_slot", 32'(alloc_slot_o), 32'd3);
        cyc(1, 0, 0, 0, 0);

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 2);
        cyc(0, 0, 1, 0, 4);
        chk("four_free_count", 32'(free_count_o), 32'd4);
        cyc(1, 1, 1, 1, 5);
        chk("same_vc_count", 32'(free_count_o), 32'd4);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("tail_slot5", 32'(alloc_slot_o), 32'd5);
        cyc(1, 1, 0, 0, 0);
        chk("drained_empty", 32'(pool_empty_o), 32'd1);

        // Illegal frees: pool already full, then a VC owning nothing
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("illegal_ptr_hold", 32'(alloc_slot_o), 32'd1);
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk("pre_reset_count", 32'(free_count_o), 32'd3);

        // Asynchronous reset between clock edges, mid-burst
        alloc_req_i = 1'b1;
        alloc_vc_i  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_free_count", 32'(free_count_o), 32'd8);
        chk("async_alloc_slot", 32'(alloc_slot_o), 32'd0);
        chk("async_vc_can", 32'(vc_can_alloc_o), 32'b11);
        chk("async_pool_empty", 32'(pool_empty_o), 32'd0);
        chk("async_free_error", 32'(free_error_o), 32'd0);
        alloc_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_reset_slot", 32'(alloc_slot_o), 32'd0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
